// File: rtl/force_capture_pipe_out_pkg.sv
// Shared constants for the simulation-result capture / host pipe-out path.
// Holds endpoint addresses, word widths and default buffer geometry.
// No logic; imported by the capture buffer and its storage.
package force_capture_pipe_out_pkg;

  localparam int OK_PIPE_WORD_W      = 16;
  localparam int SAMPLE_W            = 32;

  localparam int DEFAULT_DEPTH       = 1024;
  localparam int DEFAULT_ADDR_W      = 10;
  localparam int DEFAULT_BLOCK_WORDS = 256;

  // Host endpoint map: waveform loader in, simulation results out.
  localparam logic [7:0] EP_PIPE_IN_ADDR  = 8'h80;
  localparam logic [7:0] EP_PIPE_OUT_ADDR = 8'hA0;

endpackage

// File: rtl/force_capture_pipe_out_ram.sv
// Capture storage: DEPTH x SAMPLE_W, synchronous write, asynchronous read.
// Latency: write visible on the cycle after the write edge; read is combinational.
// No backpressure; the caller guarantees it never writes a live entry.
module force_capture_pipe_out_ram
  import force_capture_pipe_out_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Sample storage; contents are not reset, validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/force_capture_pipe_out.sv
// Buffers one 32-bit sim sample per tick and streams it to the host as 16-bit words, low half first.
// Latency: pipe_data shows the next word the cycle after pipe_read; word_count/pipe_ready lag state by one cycle.
// Full buffer drops new samples (sticky overflow); reads while empty are ignored (sticky underflow).
module force_capture_pipe_out
  import force_capture_pipe_out_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      capture_en,
  input  logic                      sample_valid,
  input  logic [SAMPLE_W-1:0]       sample_data,
  input  logic                      pipe_read,
  output logic [OK_PIPE_WORD_W-1:0] pipe_data,
  output logic                      pipe_ready,
  output logic [ADDR_W+1:0]         word_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] BLOCK_LVL  = (ADDR_W+2)'(BLOCK_WORDS);

  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     count;
  logic                half;
  logic [SAMPLE_W-1:0] head;

  logic                wr_fire;
  logic                rd_fire;
  logic                full;
  logic                empty;
  logic                do_write;
  logic                pop;
  logic [ADDR_W+1:0]   words_now;

  // clear masks both request paths so a flush cycle neither stores, pops nor flags.
  assign wr_fire   = sample_valid & capture_en & ~clear;
  assign rd_fire   = pipe_read & ~clear;
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign do_write  = wr_fire & ~full;
  assign pop       = rd_fire & ~empty & half;
  assign words_now = {count, 1'b0} - {{(ADDR_W+1){1'b0}}, half};

  force_capture_pipe_out_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Head word: low half until the first read of an entry, then the high half.
  assign pipe_data = empty ? '0 : (half ? head[31:16] : head[15:0]);

  // Pointers, occupancy, half-word phase and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      half      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      half      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire && !empty) half <= ~half;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop) count <= count + 1'b1;
      else if (!do_write && pop) count <= count - 1'b1;
      if (wr_fire && full) overflow <= 1'b1;
      if (rd_fire && empty) underflow <= 1'b1;
    end
  end

  // Host-visible level and block-ready flag, taken from the settled state one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
      pipe_ready <= 1'b0;
    end else begin
      word_count <= words_now;
      pipe_ready <= (words_now >= BLOCK_LVL);
    end
  end

endmodule
